router_pkt_gen: RTL and testbench

Packet source for the 1x3 router: the transmitting end of the router's input protocol that `router_fsm` receives. On a start request it emits one packet as a sequence of bytes:

- a header byte;
- `len` payload bytes;
- a trailing parity byte.

It drives `pkt_valid` and `data_in` exactly as the router expects and stalls on `busy`. It is used as the synthesizable stimulus engine in the router top-level bench and in the FPGA loopback build.

---
 rtl/router_pkt_gen.sv | 180 ++++++++++++++++++
 tb/tb_router_pkt_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_gen
// Description : Packet source for the 1x3 router input protocol. On start it
//               emits a header byte {len,dest}, len payload bytes counting up
//               from seed, then an XOR parity byte, stalling on busy.
//               Optional build macro PKT_GEN_BAD_PARITY_EN adds a 'corrupt'
//               input that inverts the transmitted parity byte.
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_gen #(
  parameter int unsigned MIN_GAP  = 1,
  parameter int unsigned ADDR_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic [7:0] seed,
`ifdef PKT_GEN_BAD_PARITY_EN
  input  logic       corrupt,
`endif
  input  logic       busy,
  output logic [7:0] data_in,
  output logic       pkt_valid,
  output logic       ready,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PAY  = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_t;

  // Last value of the gap counter before returning to IDLE
  localparam logic [3:0] GAP_LAST = 4'(MIN_GAP - 1);

  state_t     state, state_n;
  logic [1:0] dest_q, dest_n;
  logic [5:0] len_q, len_n;
  logic [7:0] seed_q, seed_n;
  logic       corrupt_q, corrupt_n;
  logic [5:0] cnt, cnt_n;
  logic [3:0] gcnt, gcnt_n;
  logic [7:0] parity, parity_n;
  logic [7:0] data_n;
  logic       valid_n, ready_n, done_n, err_n;
  logic       corrupt_in;
  logic       args_legal;
  logic [7:0] par_acc;

`ifdef PKT_GEN_BAD_PARITY_EN
  assign corrupt_in = corrupt;
`else
  assign corrupt_in = 1'b0;
`endif

  assign args_legal = ({30'd0, dest} <= ADDR_MAX) && (len != 6'd0);
  // Running parity including the payload byte currently on the bus
  assign par_acc    = parity ^ data_in;

  // State, latched arguments, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      dest_q    <= 2'd0;
      len_q     <= 6'd0;
      seed_q    <= 8'd0;
      corrupt_q <= 1'b0;
      cnt       <= 6'd0;
      gcnt      <= 4'd0;
      parity    <= 8'd0;
      data_in   <= 8'd0;
      pkt_valid <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      dest_q    <= dest_n;
      len_q     <= len_n;
      seed_q    <= seed_n;
      corrupt_q <= corrupt_n;
      cnt       <= cnt_n;
      gcnt      <= gcnt_n;
      parity    <= parity_n;
      data_in   <= data_n;
      pkt_valid <= valid_n;
      ready     <= ready_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  // Next-state and next-output logic; outputs are the registered image of
  // the state being entered, so busy simply leaves everything held
  always_comb begin
    state_n   = state;
    dest_n    = dest_q;
    len_n     = len_q;
    seed_n    = seed_q;
    corrupt_n = corrupt_q;
    cnt_n     = cnt;
    gcnt_n    = gcnt;
    parity_n  = parity;
    data_n    = data_in;
    valid_n   = pkt_valid;
    ready_n   = ready;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (args_legal) begin
            dest_n    = dest;
            len_n     = len;
            seed_n    = seed;
            corrupt_n = corrupt_in;
            state_n   = HDR;
            data_n    = {len, dest};
            valid_n   = 1'b1;
            ready_n   = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      HDR: begin
        if (!busy) begin
          parity_n = data_in;
          cnt_n    = 6'd0;
          state_n  = PAY;
          data_n   = seed_q;
        end
      end
      PAY: begin
        if (!busy) begin
          parity_n = par_acc;
          if (cnt == len_q - 6'd1) begin
            state_n = PAR;
            data_n  = corrupt_q ? ~par_acc : par_acc;
            valid_n = 1'b0;
          end else begin
            cnt_n  = cnt + 6'd1;
            data_n = seed_q + {2'b00, cnt + 6'd1};
          end
        end
      end
      PAR: begin
        if (!busy) begin
          state_n = GAP;
          gcnt_n  = 4'd0;
          data_n  = 8'd0;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        if (gcnt == GAP_LAST) begin
          state_n = IDLE;
          ready_n = 1'b1;
        end else begin
          gcnt_n = gcnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        data_n  = 8'd0;
        valid_n = 1'b0;
        ready_n = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_gen
// Description : Self-checking bench for router_pkt_gen (default build) with a
//               packet-level reference model and randomized busy/arguments.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_gen;

  localparam int MIN_GAP  = 1;
  localparam int ADDR_MAX = 2;
  localparam int BUDGET   = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest = 2'd0;
  logic [5:0] len = 6'd0;
  logic [7:0] seed = 8'd0;
  logic       busy = 1'b0;
  logic [7:0] data_in;
  logic       pkt_valid, ready, done, err;

  int checks = 0;
  int failures = 0;

  router_pkt_gen #(.MIN_GAP(MIN_GAP), .ADDR_MAX(ADDR_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .dest(dest), .len(len), .seed(seed),
    .busy(busy), .data_in(data_in), .pkt_valid(pkt_valid), .ready(ready),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Sends one packet and checks every presented byte against the model.
  // mode: 0 = no busy, 1 = random busy and junk start, 2 = 3-cycle stall on
  // first payload byte. hold keeps start high with the next packet's args.
  task automatic run_packet(input logic [1:0] d, input logic [5:0] l,
                            input logic [7:0] s, input int mode, input bit hold,
                            input logic [1:0] nd, input logic [5:0] nl,
                            input logic [7:0] ns);
    logic [7:0] exp_b [0:64];
    logic [7:0] p;
    int L, idx, cyc, stall_left;
    bit b;
    L = int'(l);
    exp_b[0] = {l, d};
    p = exp_b[0];
    for (int i = 0; i < L; i++) begin
      exp_b[i+1] = s + 8'(i);
      p = p ^ exp_b[i+1];
    end
    exp_b[L+1] = p;

    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL pkt_precond ready=%b required=1", ready);
    end
    start = 1'b1; dest = d; len = l; seed = s;
    @(negedge clk);
    if (hold) begin dest = nd; len = nl; seed = ns; end
    else start = 1'b0;

    idx = 0; cyc = 0; stall_left = (mode == 2) ? 3 : 0;
    while (idx <= L + 1 && cyc < BUDGET) begin
      checks++;
      if (data_in !== exp_b[idx] || pkt_valid !== (idx <= L) || ready !== 1'b0 ||
          done !== 1'b0 || err !== 1'b0) begin
        failures++;
        $display("FAIL pkt_byte idx=%0d got data=%h valid=%b ready=%b done=%b err=%b required data=%h valid=%b ready=0 done=0 err=0",
                 idx, data_in, pkt_valid, ready, done, err, exp_b[idx], (idx <= L));
      end
      if (mode == 1) b = ($urandom_range(0, 3) == 0);
      else if (mode == 2 && idx == 1 && stall_left > 0) begin b = 1'b1; stall_left--; end
      else b = 1'b0;
      if (mode == 1 && !hold) begin
        start = 1'($urandom_range(0, 1));
        dest = 2'($urandom); len = 6'($urandom); seed = 8'($urandom);
      end
      busy = b;
      @(negedge clk);
      if (!b) idx++;
      cyc++;
    end
    if (cyc >= BUDGET) begin
      checks++; failures++;
      $display("FAIL pkt_timeout idx=%0d required=%0d", idx, L + 2);
    end
    if (!hold) start = 1'b0;
    busy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

    checks++;
    if (done !== 1'b1 || pkt_valid !== 1'b0 || data_in !== 8'h00 || ready !== 1'b0) begin
      failures++;
      $display("FAIL pkt_done got done=%b valid=%b data=%h ready=%b required 1 0 00 0",
               done, pkt_valid, data_in, ready);
    end
    for (int g = 1; g < MIN_GAP; g++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b0 || pkt_valid !== 1'b0) begin
        failures++;
        $display("FAIL pkt_gap got done=%b ready=%b valid=%b required 0 0 0", done, ready, pkt_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || pkt_valid !== 1'b0 || data_in !== 8'h00) begin
      failures++;
      $display("FAIL pkt_ready got ready=%b done=%b valid=%b data=%h required 1 0 0 00",
               ready, done, pkt_valid, data_in);
    end
    busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || pkt_valid !== 1'b0 || data_in !== 8'h00 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_held got ready=%b valid=%b data=%h done=%b err=%b required 1 0 00 0 0",
               ready, pkt_valid, data_in, done, err);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || pkt_valid !== 1'b0 || data_in !== 8'h00 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b valid=%b data=%h done=%b err=%b required 1 0 00 0 0",
               ready, pkt_valid, data_in, done, err);
    end
  endtask

  task automatic test_basic();
    run_packet(2'd0, 6'd3, 8'h10, 0, 1'b0, 2'd0, 6'd0, 8'd0);
  endtask

  task automatic test_stall();
    run_packet(2'd2, 6'd2, 8'hFF, 2, 1'b0, 2'd0, 6'd0, 8'd0);
  endtask

  task automatic test_illegal();
    logic [1:0] dv [0:1];
    logic [5:0] lv [0:1];
    dv[0] = 2'd3; lv[0] = 6'd5;
    dv[1] = 2'd1; lv[1] = 6'd0;
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; dest = dv[t]; len = lv[t]; seed = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || ready !== 1'b1 || pkt_valid !== 1'b0) begin
        failures++;
        $display("FAIL illegal_err case=%0d got err=%b ready=%b valid=%b required 1 1 0",
                 t, err, ready, pkt_valid);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || ready !== 1'b1 || pkt_valid !== 1'b0) begin
        failures++;
        $display("FAIL illegal_after case=%0d got err=%b ready=%b valid=%b required 0 1 0",
                 t, err, ready, pkt_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    s = 8'($urandom);
    start = 1'b1; dest = 2'd1; len = 6'd5; seed = s;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (data_in !== s + 8'd1 || pkt_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pay1 got data=%h valid=%b required %h 1", data_in, pkt_valid, s + 8'd1);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (pkt_valid !== 1'b0 || data_in !== 8'h00 || ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_drop got valid=%b data=%h ready=%b done=%b required 0 00 1 0",
               pkt_valid, data_in, ready, done);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (pkt_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_idle cyc=%0d got valid=%b done=%b ready=%b required 0 0 1",
                 c, pkt_valid, done, ready);
      end
    end
    run_packet(2'd1, 6'd5, s, 0, 1'b0, 2'd0, 6'd0, 8'd0);
  endtask

  task automatic test_back_to_back();
    run_packet(2'd1, 6'd4, 8'hF0, 0, 1'b1, 2'd2, 6'd1, 8'h7E);
    run_packet(2'd2, 6'd1, 8'h7E, 0, 1'b0, 2'd0, 6'd0, 8'd0);
  endtask

  task automatic test_random();
    run_packet(2'd2, 6'd63, 8'hC3, 1, 1'b0, 2'd0, 6'd0, 8'd0);
    for (int n = 0; n < 25; n++) begin
      run_packet(2'($urandom_range(0, ADDR_MAX)), 6'($urandom_range(1, 20)),
                 8'($urandom), 1, 1'b0, 2'd0, 6'd0, 8'd0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
